// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the instruction-fetch path and the
// load/store data path. One transaction is in flight at a time:
//   IDLE  -> grant a requester, latch its fields and owner
//   ISSUE -> hold m_req with the latched fields until m_ready
//   WAIT  -> wait for m_rvalid and return the data to the owner
// Data has priority; a saturating starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants taken while fetch was waiting.
// A timer aborts a transaction that spends too long in ISSUE+WAIT and
// returns bus_err with zero data so a dead memory cannot hang the core.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (held until if_ready)
//   if_ready                   fetch accepted (combinational)
//   if_rvalid/if_rdata         fetch response pulse / data (registered)
//   d_req/d_we/d_size/d_addr/d_wdata   data request (held until d_ready)
//   d_ready                    data accepted (combinational)
//   d_rvalid/d_rdata           data response pulse / data (registered)
//   m_req/m_we/m_size/m_addr/m_wdata   memory request (registered)
//   m_ready/m_rvalid/m_rdata   memory handshake and response
//   bus_err                    timeout pulse, coincident with owner rvalid
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [2:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        bus_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Saturating increment for the starvation counter.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v >= SW'(STARVE_LIMIT)) return SW'(STARVE_LIMIT);
    else                        return v + 1'b1;
  endfunction

  state_t      state_q,   state_d;
  logic        owner_q,   owner_d;     // 1 = data path owns the transaction
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic        m_req_q,   m_req_d;
  logic        m_we_q,    m_we_d;
  logic [2:0]  m_size_q,  m_size_d;
  logic [31:0] m_addr_q,  m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q,  d_rvalid_d;
  logic        bus_err_q,   bus_err_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] d_rdata_q,   d_rdata_d;

  logic starve_hit;
  logic grant_f;
  logic grant_d;
  logic timeout;

  assign starve_hit = (starve_q >= SW'(STARVE_LIMIT));
  assign grant_d    = (state_q == S_IDLE) && d_req  && (!if_req || !starve_hit);
  assign grant_f    = (state_q == S_IDLE) && if_req && (!d_req  ||  starve_hit);

  // The timer holds 0 on the first ISSUE cycle; the abort is decided on the
  // cycle it steps to TIMEOUT-1, so the error pulse lands TIMEOUT cycles
  // after the accept, exactly where a normal response would surface.
  assign timeout    = (timer_q == TW'(TIMEOUT - 2));

  // Ready is decoded combinationally but must still read 0 while in reset.
  assign if_ready = grant_f & reset;
  assign d_ready  = grant_d & reset;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    timer_d     = timer_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_size_d    = m_size_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_f) begin
          owner_d   = 1'b0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_size_d  = 3'b010;
          m_addr_d  = if_addr;
          m_wdata_d = 32'h0;
          timer_d   = '0;
          starve_d  = '0;
          state_d   = S_ISSUE;
        end else if (grant_d) begin
          owner_d   = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_size_d  = d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          timer_d   = '0;
          // Only a data grant that actually made fetch wait counts.
          if (if_req) starve_d = sat_inc(starve_q);
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        timer_d = timer_q + 1'b1;
        if (timeout) begin
          m_req_d   = 1'b0;
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
          if (owner_q) begin d_rvalid_d  = 1'b1; d_rdata_d  = 32'h0; end
          else         begin if_rvalid_d = 1'b1; if_rdata_d = 32'h0; end
        end else if (m_ready) begin
          m_req_d = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A response arriving on the expiry cycle still completes normally.
        if (m_rvalid) begin
          state_d = S_IDLE;
          if (owner_q) begin d_rvalid_d  = 1'b1; d_rdata_d  = m_rdata; end
          else         begin if_rvalid_d = 1'b1; if_rdata_d = m_rdata; end
        end else if (timeout) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
          if (owner_q) begin d_rvalid_d  = 1'b1; d_rdata_d  = 32'h0; end
          else         begin if_rvalid_d = 1'b1; if_rdata_d = 32'h0; end
        end
      end

      default: begin
        state_d = S_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      timer_q     <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_size_q    <= 3'b000;
      m_addr_q    <= 32'h0;
      m_wdata_q   <= 32'h0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      timer_q     <= timer_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_size_q    <= m_size_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_size    = m_size_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=255). A table of
// single transactions with hand-computed latency and data is replayed, then
// hand-written sequences cover reset during WAIT, fetch starvation and the
// response timeout. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [2:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        bus_err;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          rdy_dly;   // extra ISSUE cycles before m_ready
    int          rv_dly;    // extra WAIT cycles before m_rvalid
    int          lat;       // expected cycles from accept to owner rvalid
    logic        exp_we;
    logic [2:0]  exp_size;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] last_if_rdata = 32'h0;
  logic [31:0] last_d_rdata  = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ready"},  {30'h0, if_ready, d_ready}, 32'h0);
    chk({tag, " rvalid"}, {29'h0, if_rvalid, d_rvalid, bus_err}, 32'h0);
    chk({tag, " if_rdata"}, if_rdata, 32'h0);
    chk({tag, " d_rdata"},  d_rdata, 32'h0);
    chk({tag, " m_ctl"},  {27'h0, m_req, m_we, m_size}, 32'h0);
    chk({tag, " m_addr"},  m_addr, 32'h0);
    chk({tag, " m_wdata"}, m_wdata, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int first_rv = -1;
    int n_rv = 0, n_mreq = 0, n_unstable = 0, n_other = 0, n_err = 0;
    logic [31:0] a0 = 32'h0, wd0 = 32'h0, rd_at = 32'h0;
    logic        we0 = 1'b0;
    logic [2:0]  sz0 = 3'b0;
    string       p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk({p, " if_ready"}, {31'h0, if_ready}, {31'h0, ~v.is_d});
    chk({p, " d_ready"},  {31'h0, d_ready},  {31'h0, v.is_d});
    @(posedge clk);
    for (int k = 1; k <= v.lat + 2; k++) begin
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
      // Scramble request fields: the memory side must use latched copies.
      if_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we; d_size = ~v.size;
      if (k == 1) begin a0 = m_addr; we0 = m_we; sz0 = m_size; wd0 = m_wdata; end
      if (m_req) begin
        n_mreq++;
        if (m_addr !== a0 || m_we !== we0 || m_size !== sz0 || m_wdata !== wd0) n_unstable++;
      end
      if ((v.is_d ? d_rvalid : if_rvalid) === 1'b1) begin
        n_rv++;
        if (first_rv < 0) begin first_rv = k; rd_at = v.is_d ? d_rdata : if_rdata; end
      end
      if ((v.is_d ? if_rvalid : d_rvalid) === 1'b1) n_other++;
      if (bus_err === 1'b1) n_err++;
      m_ready  = (k == 1 + v.rdy_dly);
      m_rvalid = (k == 2 + v.rdy_dly + v.rv_dly);
      m_rdata  = m_rvalid ? v.mrdata : 32'hA5A5_5A5A;
    end
    m_ready = 1'b0; m_rvalid = 1'b0;
    chk({p, " latency"},     first_rv, v.lat);
    chk({p, " rvalid_cnt"},  n_rv, 1);
    chk({p, " rdata"},       rd_at, v.exp_rdata);
    chk({p, " mreq_cycles"}, n_mreq, 1 + v.rdy_dly);
    chk({p, " m_stable"},    n_unstable, 0);
    chk({p, " m_addr"},      a0, v.addr);
    chk({p, " m_we"},        {31'h0, we0}, {31'h0, v.exp_we});
    chk({p, " m_size"},      {29'h0, sz0}, {29'h0, v.exp_size});
    if (v.is_d) chk({p, " m_wdata"}, wd0, v.wdata);
    chk({p, " other_rvalid"}, n_other, 0);
    chk({p, " bus_err"},     n_err, 0);
    if (v.is_d) begin
      chk({p, " if_rdata_hold"}, if_rdata, last_if_rdata);
      last_d_rdata = v.exp_rdata;
    end else begin
      chk({p, " d_rdata_hold"}, d_rdata, last_d_rdata);
      last_if_rdata = v.exp_rdata;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          is_d we  size    addr          wdata         mrdata        rdy rv  lat  we  size    rdata
    vecs[0] = '{1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h0050_0093, 0, 0,   3,   1'b0, 3'b010, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 32'h1357_9BDF, 3, 0,   6,   1'b1, 3'b010, 32'h1357_9BDF};
    vecs[2] = '{1'b1, 1'b0, 3'b100, 32'h0000_3004, 32'h0000_0055, 32'h0000_00AB, 0, 2,   5,   1'b0, 3'b100, 32'h0000_00AB};
    vecs[3] = '{1'b0, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'hFFF0_0113, 1, 1,   5,   1'b0, 3'b010, 32'hFFF0_0113};
    vecs[4] = '{1'b1, 1'b0, 3'b001, 32'h0000_0040, 32'h0,        32'h8000_1234, 0, 0,   3,   1'b0, 3'b001, 32'h8000_1234};
    // Response lands on the very cycle the timer expires: it must win.
    vecs[5] = '{1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0,        32'h0BAD_C0DE, 0, 252, 255, 1'b0, 3'b010, 32'h0BAD_C0DE};

    reset = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_size = 3'b0; d_addr = 32'h0; d_wdata = 32'h0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;

    repeat (2) @(negedge clk);
    if_req = 1'b1; d_req = 1'b1;
    #1;
    chk_all_zero("por");
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset during WAIT of a load, then a stale response after release.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b000; d_addr = 32'h0000_6000;
    #1;
    chk("rst_seq d_ready", {31'h0, d_ready}, 32'h1);
    @(negedge clk);
    d_req = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("rst_seq in_wait m_req", {31'h0, m_req}, 32'h0);
    @(negedge clk);
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0300;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk);
    chk_all_zero("rst_hold");
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("rst_seq stale rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
    chk("rst_seq stale bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_seq d_rdata", d_rdata, 32'h0);
    last_if_rdata = 32'h0; last_d_rdata = 32'h0;
    run_vec(6, vecs[0]);

    // Both requesters held: D,D,D,D,F,D,D,D,D,F at one grant per 3 cycles.
    begin
      logic [9:0] order = '0;
      int ng = 0, both = 0;
      int gcyc[10];
      logic rv_pend = 1'b0;
      for (int c = 0; c < 60 && ng < 10; c++) begin
        @(negedge clk);
        m_rvalid = rv_pend; m_rdata = 32'h0000_0077; rv_pend = 1'b0;
        m_ready = m_req;
        if (m_req) rv_pend = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h0000_0800;
        #1;
        if (if_ready && d_ready) both++;
        if (if_ready || d_ready) begin
          order = {order[8:0], d_ready};
          gcyc[ng] = c;
          ng++;
        end
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        m_rvalid = rv_pend; rv_pend = 1'b0;
        m_ready = m_req;
        if (m_req) rv_pend = 1'b1;
      end
      m_ready = 1'b0; m_rvalid = 1'b0;
      chk("starve grant_cnt", ng, 10);
      chk("starve grant_order", {22'h0, order}, 32'h0000_03DE);
      chk("starve both_ready", both, 0);
      if (ng == 10) chk("starve spacing", gcyc[9] - gcyc[0], 27);
      chk("starve if_rdata", if_rdata, 32'h0000_0077);
      last_if_rdata = 32'h0000_0077; last_d_rdata = 32'h0000_0077;
    end

    // Dead memory: timeout 255 cycles after accept, then a late response.
    begin
      int rv_at = -1, n_rv = 0, n_mreq = 0, n_if = 0;
      logic [31:0] rd = 32'hFFFF_FFFF;
      logic be = 1'b0;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h0000_5000;
      #1;
      chk("tmo d_ready", {31'h0, d_ready}, 32'h1);
      @(posedge clk);
      for (int k = 1; k <= 256; k++) begin
        @(negedge clk);
        d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
        if (m_req) n_mreq++;
        if (if_rvalid) n_if++;
        if (d_rvalid) begin
          n_rv++;
          if (rv_at < 0) begin rv_at = k; rd = d_rdata; be = bus_err; end
        end
        if (k == 256) begin m_rvalid = 1'b1; m_rdata = 32'h1234_5678; end
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      chk("tmo latency", rv_at, 255);
      chk("tmo rvalid_cnt", n_rv, 1);
      chk("tmo bus_err", {31'h0, be}, 32'h1);
      chk("tmo d_rdata", rd, 32'h0);
      chk("tmo mreq_cycles", n_mreq, 254);
      chk("tmo if_rvalid", n_if, 0);
      chk("tmo late rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
      chk("tmo late d_rdata", d_rdata, 32'h0);
      chk("tmo if_rdata_hold", if_rdata, last_if_rdata);
      last_d_rdata = 32'h0;
    end
    run_vec(7, vecs[3]);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester scheduler that shares one single-port unified memory between the core's instruction-fetch path and its load/store data path. It grants one request at a time, forwards it to the memory, and routes the returned data to the owner. Data accesses have priority, and a bounded starvation counter keeps fetch from being locked out. A response timeout keeps a dead memory from hanging the core. It sits between the datapath's pc/instr and aluout/writedata/readdata/memwrite/memsize signals and the memory model.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced through. Must be ≥ 1.
- TIMEOUT, 255: cycles a transaction may spend in ISSUE+WAIT before it is aborted. Must be ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request. Held stable until if_ready.
- if_addr  in  32  fetch address.
- if_ready  out  1  fetch request accepted this cycle. Combinational.
- if_rvalid  out  1  one-cycle pulse: fetch response valid.
- if_rdata  out  32  fetch data. Registered.
- d_req  in  1  data request. Held stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  3  access size, passed through unchanged (memsize encoding).
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ready  out  1  data request accepted this cycle. Combinational.
- d_rvalid  out  1  one-cycle pulse: data response valid (loads and stores).
- d_rdata  out  32  load data. Registered.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_size  out  3  memory access size.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_ready  in  1  memory accepts m_req this cycle.
- m_rvalid  in  1  memory response. Asserted once per accepted request, including writes.
- m_rdata  in  32  memory read data.
- bus_err  out  1  one-cycle pulse, asserted together with the owner's rvalid on timeout.

## Operation
- FSM states:
  - IDLE: no transaction in flight. If any request is pending, grant one: assert that requester's ready, latch its fields and owner, clear the timer, go to ISSUE.
  - ISSUE: drive m_req=1 with the latched fields. On m_ready, go to WAIT.
  - WAIT: wait for m_rvalid. On m_rvalid, go to IDLE, pulse owner_rvalid, and load owner_rdata with m_rdata.
- Fetch grants always drive m_we=0 and m_size=3'b010 (word). Data grants drive d_we, d_size and d_wdata. Store responses pulse d_rvalid; d_rdata is loaded with m_rdata as returned.
- Arbitration in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant data unless starve_cnt ≥ STARVE_LIMIT, in which case grant fetch.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on a data grant made while if_req=1.
  - Clears on any fetch grant.
  - Unchanged on a data grant made while if_req=0.
- Timer: counts every cycle in ISSUE and WAIT. When it reaches TIMEOUT-1 without completion:
  - drop m_req;
  - go to IDLE;
  - pulse owner_rvalid together with bus_err;
  - load owner_rdata with 0.
- If m_rvalid arrives in the same cycle as the timeout, the response wins: normal completion, bus_err=0.
- m_rvalid outside WAIT is ignored. This includes a late response after a timeout or after reset.
- The non-owner's rdata holds its previous value.
- Reset, asserted at any time:
  - immediately returns to IDLE;
  - clears starve_cnt, timer, all latched fields, if_rdata and d_rdata;
  - forces every output to 0.
  - A transaction in flight is discarded and no rvalid is produced for it.

## Timing
- All outputs are registered except if_ready and d_ready, which are decoded from state, the request inputs and starve_cnt.
- Minimum latency with m_ready=1 in ISSUE and m_rvalid on the first WAIT cycle:
  - cycle T: accept (ready=1);
  - T+1: m_req=1;
  - T+2: m_rvalid;
  - T+3: owner rvalid=1.
- The FSM is in IDLE at T+3, so a new accept can occur in the same cycle as the previous rvalid. Peak throughput is one transaction per 3 cycles.
- m_req and its fields are stable from ISSUE entry until the cycle m_ready is sampled high.
- ready is never asserted outside IDLE. At most one ready is high per cycle.

## Test plan
- Single fetch, if_addr=0x100, memory returns 0x00500093 at minimum latency: if_ready at T, m_req/m_addr=0x100/m_we=0 at T+1, if_rvalid=1 with if_rdata=0x00500093 at T+3, d_rvalid stays 0.
- Store, d_addr=0x2000, d_wdata=0xDEADBEEF, d_size=3'b010, memory delays m_ready 3 cycles: m_req held high with stable fields for 4 cycles, d_rvalid pulses once, bus_err=0.
- if_req and d_req held continuously, STARVE_LIMIT=4: grant order is D,D,D,D,F,D,D,D,D,F…
- Memory never answers, TIMEOUT=255: exactly 255 cycles after accept, d_rvalid=1, bus_err=1, d_rdata=0, FSM in IDLE. A late m_rvalid afterwards produces no pulse.
- Reset driven low during WAIT of a load, then released, then m_rvalid arrives: all outputs 0 during reset, no d_rvalid, next fetch request is served normally.
- m_rvalid in the same cycle the timer expires: normal response with m_rdata, bus_err=0.
